// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner issuing block requests to memory and buffering in-order responses for IA.
module fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 16,
    parameter int FETCH_WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int EXC_W = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_flush,
    input  logic [ADDR_W-1:0]              i_flush_pc,
    output logic                           o_req_valid,
    output logic [ADDR_W-1:0]              o_req_addr,
    input  logic                           i_req_ready,
    input  logic                           i_resp_valid,
    input  logic [FETCH_WIDTH*INSTR_W-1:0] i_resp_data,
    input  logic [EXC_W-1:0]               i_resp_except,
    output logic                           o_valid,
    output logic [ADDR_W-1:0]              o_pc,
    output logic [FETCH_WIDTH*INSTR_W-1:0] o_data,
    output logic [FETCH_WIDTH-1:0]         o_mask,
    output logic [EXC_W-1:0]               o_except,
    input  logic                           i_ready
);
    localparam int BLK = FETCH_WIDTH * INSTR_W / 8;
    localparam int OFF_W = $clog2(BLK);
    localparam int SLOT_SH = $clog2(INSTR_W / 8);
    localparam int DW = FETCH_WIDTH * INSTR_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_O = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEP = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] BLK_A = ADDR_W'(BLK);
    localparam logic [ADDR_W-1:0] ALIGN = ~(BLK_A - ADDR_W'(1));

    logic                   run, halt;
    logic [ADDR_W-1:0]      pc, resp_pc;
    logic [CW-1:0]          outstanding, drop, count, out_next;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]      pc_mem   [DEPTH];
    logic [DW-1:0]          data_mem [DEPTH];
    logic [FETCH_WIDTH-1:0] mask_mem [DEPTH];
    logic [EXC_W-1:0]       exc_mem  [DEPTH];
    logic                   req_ok, accept, push, pop;
    logic [OFF_W-1:0]       first_slot;
    logic [FETCH_WIDTH-1:0] in_mask;

    // resp_pc tracks the PC of the next non-dropped response; only the first block after a redirect is unaligned
    always_comb begin
        req_ok = run && !halt && outstanding < MAX_O && (outstanding + count) < DEP;
        accept = req_ok && i_req_ready;
        push = i_resp_valid && drop == '0 && !i_flush;
        o_valid = count != '0;
        pop = o_valid && i_ready && !i_flush;
        out_next = outstanding + CW'(accept) - CW'(i_resp_valid);
        first_slot = resp_pc[OFF_W-1:0] >> SLOT_SH;
        in_mask = (i_resp_except != '0) ? '1 : ({FETCH_WIDTH{1'b1}} << first_slot);
        o_req_valid = req_ok;
        o_req_addr = req_ok ? (pc & ALIGN) : '0;
        o_pc = o_valid ? pc_mem[rd_ptr] : '0;
        o_data = o_valid ? data_mem[rd_ptr] : '0;
        o_mask = o_valid ? mask_mem[rd_ptr] : '0;
        o_except = o_valid ? exc_mem[rd_ptr] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run <= 1'b0;
            halt <= 1'b0;
            pc <= RESET_PC;
            resp_pc <= RESET_PC;
            outstanding <= '0;
            drop <= '0;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            run <= 1'b1;
            outstanding <= out_next;
            if (i_flush) begin
                drop <= out_next;
                pc <= i_flush_pc;
                resp_pc <= i_flush_pc;
                halt <= 1'b0;
                count <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (i_resp_valid && drop != '0) drop <= drop - CW'(1);
                if (accept) pc <= (pc & ALIGN) + BLK_A;
                if (push) resp_pc <= (resp_pc & ALIGN) + BLK_A;
                if (push && i_resp_except != '0) halt <= 1'b1;
                count <= count + CW'(push) - CW'(pop);
                wr_ptr <= wr_ptr + PW'(push);
                rd_ptr <= rd_ptr + PW'(pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr] <= resp_pc;
            data_mem[wr_ptr] <= i_resp_data;
            mask_mem[wr_ptr] <= in_mask;
            exc_mem[wr_ptr] <= i_resp_except;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_resp_valid && outstanding == '0));
            assert (!(push && !pop && count == DEP));
        end
    end
endmodule
